mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Sequential accumulate stage directly downstream of the 8-bit Booth multiplier.
- Consumes a stream of 16-bit signed products over a valid/ready handshake and sums them into a saturating signed accumulator.
- On the product flagged last, presents the sum, the product count and a sticky overflow flag on a valid/ready output.
- Together with the multiplier it forms the ALU's dot-product / MAC path.

Parameters:
- PROD_W, 16: product width; two's-complement; matches multiplier output.
- ACC_W, 24: accumulator width; must be greater than PROD_W.
- CNT_W, 8: product-counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; abandons the current burst.
- in_valid  in  1  in_prod / in_last are valid.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  PROD_W  signed product from the multiplier.
- in_last  in  1  marks the final product of a burst.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  signed accumulated sum.
- out_count  out  CNT_W  number of products in the burst.
- out_ovf  out  1  saturation occurred during the burst (sticky).

Behaviour:
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (asynchronous, any time, including mid-burst): state=ACCUM; acc=0, count=0, ovf=0; out_valid=0, in_ready=1 after reset deasserts.
- Accept: in_valid & in_ready at a rising edge.
  - sum = acc + sign-extend(in_prod) to ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: acc = max positive, ovf set.
  - Below -2^(ACC_W-1): acc = most negative, ovf set.
  - Otherwise acc = sum.
  - count increments and saturates at 2^CNT_W-1; count saturation does not set ovf.
- Saturated acc is an ordinary value: later products of opposite sign add to it normally; ovf stays set until the burst ends.
- Accept with in_last=1: the last product is included; state goes to HOLD next cycle.
  - out_valid rises the cycle after the last accept, so latency is 1 cycle.
  - A burst of one product (in_last on the first accept) is legal.
- out_acc, out_count and out_ovf:
  - Are registered and driven directly from acc / count / ovf.
  - Must remain stable while out_valid=1 and out_ready=0.
  - Are not defined as meaningful while out_valid=0; the bench must not check them then.
- HOLD with out_ready=1 at an edge: handshake completes; acc, count and ovf clear to 0; state returns to ACCUM, so in_ready=1 next cycle.
  - No input is accepted in the handshake cycle, giving one bubble per burst.
- in_valid while in HOLD: ignored; upstream holds its data because in_ready=0.
- clr=1 at an edge:
  - Has priority over accept and output handshake.
  - acc, count, ovf go to 0; state goes to ACCUM.
  - A pending result is discarded: out_valid drops next cycle.
  - A product presented in the same cycle is dropped.
- in_ready depends only on state, never combinationally on in_valid; out_valid depends only on state.

Test Plan:
- Products 0x0003, 0xFFFE, 0x0064 with in_last on the third, out_ready=1 -> one cycle later out_valid=1, out_acc=0x000065 (101), out_count=3, out_ovf=0; acc, count and ovf cleared after the handshake.
- Burst completes with out_ready held low 5 cycles while in_valid stays high -> in_ready=0 for all 5 cycles, outputs stable, no product accepted; out_ready=1 -> next product accepted into a zero accumulator.
- 257 products of 0x7FFF, last flagged -> out_acc=0x7FFFFF, out_ovf=1, out_count=255 (saturated); a following burst starts with out_ovf=0.
- 256 products of 0x8000 -> out_acc=0x800000, out_ovf=0. Repeat with one extra 0xFFFF, then 0x0001 last -> out_acc=0x800001, out_ovf=1 (sticky).
- rst asserted asynchronously between edges mid-burst (acc nonzero) -> outputs clear immediately; after release, burst 0x0010 last -> out_acc=0x000010, count=1. Same burst with clr pulsed mid-burst -> only products after clr are summed.
- clr asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, in_ready=1, no result ever handshaked for that burst.

Source files
------------

// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Saturating signed accumulate stage that sits after the Booth multiplier.
// It sums a burst of signed products into a saturating accumulator. When the
// product flagged last has been added, it presents the sum, the product count
// and a sticky overflow flag on a valid/ready output port.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   clr        in   1       synchronous clear; abandons the current burst
//   in_valid   in   1       in_prod / in_last are valid
//   in_ready   out  1       block accepts a product this cycle (state only)
//   in_prod    in   PROD_W  two's-complement product
//   in_last    in   1       final product of the burst
//   out_valid  out  1       result available (state only)
//   out_ready  in   1       consumer accepts the result
//   out_acc    out  ACC_W   signed accumulated sum (saturating)
//   out_count  out  CNT_W   products in the burst (saturating)
//   out_ovf    out  1       saturation occurred during the burst (sticky)
//
// ACC_W must be greater than PROD_W.
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,  // collecting products
    HOLD  = 1'b1   // presenting the result
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;

  logic               accept;
  logic               handshake;
  logic [ACC_W:0]     sum;      // one guard bit so overflow is visible
  logic               sum_pos_ovf;
  logic               sum_neg_ovf;

  // Handshake flags depend only on state, never on in_valid / out_ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign accept    = in_ready  & in_valid;
  assign handshake = out_valid & out_ready;

  // Both operands are sign-extended to ACC_W+1 bits. Their sum can then never
  // wrap. The two top bits disagree exactly when the result falls outside the
  // ACC_W range.
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};

  assign sum_pos_ovf = ~sum[ACC_W] &  sum[ACC_W-1];
  assign sum_neg_ovf =  sum[ACC_W] & ~sum[ACC_W-1];

  // NOTE: every next-state signal gets its hold value first. Without that,
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clr) begin
      // clr wins over both handshakes. A product presented in the same
      // cycle is dropped, and a pending result is discarded.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (sum_pos_ovf) begin
        acc_d = ACC_MAX;
        ovf_d = 1'b1;
      end else if (sum_neg_ovf) begin
        acc_d = ACC_MIN;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end

      // Count saturation is not treated as an overflow.
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (in_last) begin
        state_d = HOLD;
      end
    end else if (handshake) begin
      // Nothing is accepted in this cycle, so each burst costs one bubble.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments. Every register then
  // samples its value from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // The result outputs come straight from registers. They stay stable while
  // HOLD waits for out_ready.
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Directed bench for mac_accumulator. It keeps a behavioural model of the
// accumulate stage in plain integer arithmetic. A compare process checks the
// DUT against that model on every falling edge. Each burst result is also
// checked against a hand-computed literal.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam longint ACC_MAX_I = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN_I = -(64'sd1 <<< (ACC_W-1));
  localparam int     CNT_MAX_I = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int checks   = 0;
  int failures = 0;

  mac_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a plain integer sum clamped to the ACC_W range, a
  // clamped count, a sticky flag, and a "result pending" bit.
  // ---------------------------------------------------------------------------
  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     m_pending;

  function automatic longint clamp(input longint v);
    if (v > ACC_MAX_I) return ACC_MAX_I;
    if (v < ACC_MIN_I) return ACC_MIN_I;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_pending <= 0;
    end else if (clr) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_pending <= 0;
    end else if (!m_pending && in_valid) begin
      m_acc <= clamp(m_acc + longint'($signed(in_prod)));
      if (clamp(m_acc + longint'($signed(in_prod))) != m_acc + longint'($signed(in_prod)))
        m_ovf <= 1;
      m_cnt <= (m_cnt < CNT_MAX_I) ? m_cnt + 1 : CNT_MAX_I;
      if (in_last) m_pending <= 1;
    end else if (m_pending && out_ready) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_pending <= 0;
    end
  end

  // Compare process: flags every cycle, result fields only while valid.
  always @(negedge clk) begin
    if (!rst) begin
      check("model in_ready",  {31'd0, in_ready},  {31'd0, !m_pending});
      check("model out_valid", {31'd0, out_valid}, {31'd0, m_pending});
      if (m_pending && out_valid) begin
        check("model out_acc",   {8'd0, out_acc},   {8'd0, m_acc[ACC_W-1:0]});
        check("model out_count", {24'd0, out_count}, 32'(m_cnt));
        check("model out_ovf",   {31'd0, out_ovf},   {31'd0, m_ovf});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all are called right after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic push(input logic [PROD_W-1:0] p, input logic l);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("push in_ready timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_prod = p; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push_n(input logic [PROD_W-1:0] p, input int n);
    for (int i = 0; i < n; i++) push(p, 1'b0);
  endtask

  // Wait (bounded) for the result, check literals, then handshake it.
  task automatic take_result(input string name, input logic [ACC_W-1:0] acc,
                             input logic [CNT_W-1:0] cnt, input logic ovf);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, " valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " acc"},   {8'd0, out_acc},    {8'd0, acc});
    check({name, " count"}, {24'd0, out_count}, {24'd0, cnt});
    check({name, " ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    check({name, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);

    // 3 + (-2) + 100 = 101; the result is valid one cycle after the last accept.
    push(16'h0003, 1'b0);
    push(16'hFFFE, 1'b0);
    push(16'h0064, 1'b1);
    check("basic latency", {31'd0, out_valid}, 32'd1);
    take_result("basic", 24'h000065, 8'd3, 1'b0);

    // Back-pressure: a held product must wait until the result is taken.
    push(16'h0005, 1'b1);
    in_valid = 1'b1; in_prod = 16'h0007; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall acc",      {8'd0, out_acc},   32'h000005);
      check("stall count",    {24'd0, out_count}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);            // handshake edge: bubble, nothing accepted
    out_ready = 1'b0;
    check("post-stall in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);            // held product accepted into a zero accumulator
    in_valid = 1'b0; in_last = 1'b0;
    take_result("after stall", 24'h000007, 8'd1, 1'b0);

    // Positive saturation with saturated count, then sticky flag clears.
    push_n(16'h7FFF, 256);
    push(16'h7FFF, 1'b1);
    take_result("pos sat", 24'h7FFFFF, 8'd255, 1'b1);
    push(16'h0001, 1'b1);
    take_result("after pos sat", 24'h000001, 8'd1, 1'b0);

    // Landing exactly on the most negative value is not an overflow.
    push_n(16'h8000, 255);
    push(16'h8000, 1'b1);
    take_result("neg exact", 24'h800000, 8'd255, 1'b0);
    push_n(16'h8000, 256);
    push(16'hFFFF, 1'b0);
    push(16'h0001, 1'b1);
    take_result("neg sticky", 24'h800001, 8'd255, 1'b1);

    // Asynchronous reset between edges, mid-burst.
    push(16'h0100, 1'b0);
    push(16'h0200, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    push(16'h0010, 1'b1);
    take_result("after rst", 24'h000010, 8'd1, 1'b0);

    // Clear mid-burst: earlier products and the one presented alongside clr are dropped.
    push(16'h0010, 1'b0);
    push(16'h0020, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'h0040;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    push(16'h0003, 1'b0);
    push(16'h0010, 1'b1);
    take_result("after clr", 24'h000013, 8'd2, 1'b0);

    // Clear while a result is pending: it is discarded, never handshaked.
    push(16'h0005, 1'b1);
    check("pending valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr drop out_valid", {31'd0, out_valid}, 32'd0);
    check("clr drop in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("discarded stays invalid", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    push(16'h0002, 1'b1);
    take_result("after discard", 24'h000002, 8'd1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
